// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - product codes, prices, coin values and state encoding for the vending controller
package vend_pkg;

  localparam logic [1:0] PROD_NONE  = 2'b00;
  localparam logic [1:0] PROD_NEWS  = 2'b01;
  localparam logic [1:0] PROD_CHOC  = 2'b10;
  localparam logic [1:0] PROD_JUICE = 2'b11;

  localparam int DEF_PRICE_NEWS  = 5;
  localparam int DEF_PRICE_CHOC  = 10;
  localparam int DEF_PRICE_JUICE = 15;
  localparam int DEF_TIMEOUT     = 255;

  localparam logic [4:0] COIN_5  = 5'd5;
  localparam logic [4:0] COIN_10 = 5'd10;
  localparam logic [4:0] COIN_20 = 5'd20;
  localparam int         CHANGE_UNIT = 5;

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  // Only three denominations are ever credited; anything else goes back out
  function automatic logic coin_legal(input logic [4:0] value);
    return (value == COIN_5) || (value == COIN_10) || (value == COIN_20);
  endfunction

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - front-end and actuator signals of the vending controller
interface vend_if #(
  parameter int CREDIT_W = 6
);
  logic                coin_valid;
  logic [4:0]          coin_value;
  logic                coin_reject;
  logic                select_valid;
  logic [1:0]          select_product;
  logic                cancel;
  logic                insufficient;
  logic                dispense_req;
  logic [1:0]          product;
  logic                dispense_ack;
  logic                sale_done;
  logic                change_req;
  logic                change_ack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin_valid, coin_value, select_valid, select_product, cancel, dispense_ack, change_ack,
    input  coin_reject, insufficient, dispense_req, product, sale_done, change_req, credit, busy
  );

  modport slave (
    input  coin_valid, coin_value, select_valid, select_product, cancel, dispense_ack, change_ack,
    output coin_reject, insufficient, dispense_req, product, sale_done, change_req, credit, busy
  );
endinterface

// File: rtl/vend_idle_timer.sv
// rtl/vend_idle_timer.sv - reloadable down-counter that flags inactivity while a customer holds credit
module vend_idle_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);
  localparam int                CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Reload on clear, otherwise count down while running and park at zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (run && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == '0);
endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin credit, product selection, dispense handshake and change return
module vend_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 6,
  parameter int MAX_CREDIT  = 35,
  parameter int PRICE_NEWS  = DEF_PRICE_NEWS,
  parameter int PRICE_CHOC  = DEF_PRICE_CHOC,
  parameter int PRICE_JUICE = DEF_PRICE_JUICE,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input logic   clock,
  input logic   reset,
  vend_if.slave bus
);
  localparam logic [CREDIT_W-1:0] UNIT  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [CREDIT_W:0]   LIMIT = (CREDIT_W + 1)'(MAX_CREDIT);

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit_q, credit_next;
  logic [1:0]          product_q, product_next;
  logic                reject_q, reject_next;
  logic                insuff_q, insuff_next;
  logic                dreq_q, dreq_next;
  logic                sale_q, sale_next;
  logic                creq_q, creq_next;
  logic                busy_q;
  logic [CREDIT_W-1:0] coin_amt, price;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok, sel_act, timer_clear, expire;

  // Sum is one bit wider so the MAX_CREDIT check sees the true total
  assign coin_amt = CREDIT_W'(bus.coin_value);
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_amt};
  assign coin_ok  = coin_legal(bus.coin_value) && (coin_sum <= LIMIT);
  assign sel_act  = bus.select_valid && (bus.select_product != PROD_NONE);

  vend_idle_timer #(.TIMEOUT(TIMEOUT)) idle_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .run    (state == CREDIT),
    .expire (expire)
  );

  // Price of the product currently on the keypad
  always_comb begin
    case (bus.select_product)
      PROD_NEWS:  price = CREDIT_W'(PRICE_NEWS);
      PROD_CHOC:  price = CREDIT_W'(PRICE_CHOC);
      PROD_JUICE: price = CREDIT_W'(PRICE_JUICE);
      default:    price = '0;
    endcase
  end

  // Next state, next credit and next value of every registered output
  always_comb begin
    state_next   = state;
    credit_next  = credit_q;
    product_next = PROD_NONE;
    reject_next  = 1'b0;
    insuff_next  = 1'b0;
    dreq_next    = 1'b0;
    sale_next    = 1'b0;
    creq_next    = 1'b0;
    timer_clear  = (state != CREDIT);
    unique case (state)
      IDLE: begin
        if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_next = coin_amt;
            state_next  = CREDIT;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      CREDIT: begin
        // One action per cycle: refund beats selection beats coin
        if (bus.cancel || expire) begin
          state_next  = CHANGE;
          creq_next   = 1'b1;
          reject_next = bus.coin_valid;
        end else if (sel_act) begin
          timer_clear = 1'b1;
          reject_next = bus.coin_valid;
          if (credit_q >= price) begin
            credit_next  = credit_q - price;
            product_next = bus.select_product;
            dreq_next    = 1'b1;
            state_next   = DISPENSE;
          end else begin
            insuff_next = 1'b1;
          end
        end else if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_next = coin_sum[CREDIT_W-1:0];
            timer_clear = 1'b1;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      DISPENSE: begin
        reject_next = bus.coin_valid;
        if (bus.dispense_ack) begin
          sale_next = 1'b1;
          if (credit_q == '0) begin
            state_next = IDLE;
          end else begin
            state_next = CHANGE;
            creq_next  = 1'b1;
          end
        end else begin
          dreq_next    = 1'b1;
          product_next = product_q;
        end
      end
      CHANGE: begin
        reject_next = bus.coin_valid;
        creq_next   = 1'b1;
        if (credit_q == '0) begin
          state_next = IDLE;
          creq_next  = 1'b0;
        end else if (creq_q && bus.change_ack) begin
          credit_next = credit_q - UNIT;
          if (credit_q == UNIT) begin
            state_next = IDLE;
            creq_next  = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Credit datapath and registered outputs; reset forfeits any credit held
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credit_q  <= '0;
      product_q <= PROD_NONE;
      reject_q  <= 1'b0;
      insuff_q  <= 1'b0;
      dreq_q    <= 1'b0;
      sale_q    <= 1'b0;
      creq_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      credit_q  <= credit_next;
      product_q <= product_next;
      reject_q  <= reject_next;
      insuff_q  <= insuff_next;
      dreq_q    <= dreq_next;
      sale_q    <= sale_next;
      creq_q    <= creq_next;
      busy_q    <= (state_next == DISPENSE) || (state_next == CHANGE);
    end
  end

  assign bus.credit       = credit_q;
  assign bus.product      = product_q;
  assign bus.coin_reject  = reject_q;
  assign bus.insufficient = insuff_q;
  assign bus.dispense_req = dreq_q;
  assign bus.sale_done    = sale_q;
  assign bus.change_req   = creq_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - randomized transaction bench with event scoreboard for vend_controller
module tb_vend_controller;
  localparam int TIMEOUT    = 255;
  localparam int MAX_CREDIT = 35;

  logic clock = 1'b0;
  logic reset = 1'b0;

  vend_if #(.CREDIT_W(6)) bus();

  vend_controller #(
    .CREDIT_W(6), .MAX_CREDIT(MAX_CREDIT), .PRICE_NEWS(5), .PRICE_CHOC(10),
    .PRICE_JUICE(15), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       reject;
    logic       insuff;
    logic       sale;
    logic       dreq;
    logic [1:0] prod;
    logic       creq;
    logic [5:0] credit;
    logic       busy;
  } rec_t;

  rec_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_credit    = 0;

  function automatic int price_of(input logic [1:0] p);
    case (p)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 15;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(input int v);
    return (v == 5) || (v == 10) || (v == 20);
  endfunction

  function automatic int pick_coin();
    int tbl[8] = '{5, 10, 20, 5, 10, 0, 7, 15};
    return tbl[$urandom_range(0, 7)];
  endfunction

  function automatic rec_t rec(input bit dreq, input logic [1:0] prod, input bit creq);
    rec_t r = '0;
    r.dreq   = dreq;
    r.prod   = prod;
    r.creq   = creq;
    r.credit = 6'(m_credit);
    r.busy   = dreq | creq;
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("rej=%0b ins=%0b sale=%0b dreq=%0b prod=%0d creq=%0b credit=%0d busy=%0b",
                     r.reject, r.insuff, r.sale, r.dreq, r.prod, r.creq, r.credit, r.busy);
  endfunction

  task automatic step(input bit push, input rec_t r);
    if (push) exp_q.push_back(r);
    @(posedge clock);
    #1;
    bus.coin_valid   = 1'b0;
    bus.select_valid = 1'b0;
    bus.cancel       = 1'b0;
    bus.dispense_ack = 1'b0;
    bus.change_ack   = 1'b0;
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({bus.coin_reject, bus.insufficient, bus.dispense_req, bus.product, bus.sale_done,
         bus.change_req, bus.credit, bus.busy} != '0) begin
      miscompares++;
      $display("FAIL %s: rej=%0b ins=%0b dreq=%0b prod=%0d sale=%0b creq=%0b credit=%0d busy=%0b, want all 0",
               name, bus.coin_reject, bus.insufficient, bus.dispense_req, bus.product,
               bus.sale_done, bus.change_req, bus.credit, bus.busy);
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected events never seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Coin while idle or holding credit: credited if legal and it fits
  task automatic put_coin(input int v);
    rec_t r;
    bus.coin_valid = 1'b1;
    bus.coin_value = 5'(v);
    if (legal(v) && (m_credit + v <= MAX_CREDIT)) begin
      m_credit += v;
      r = rec(0, 2'b00, 0);
    end else begin
      r = rec(0, 2'b00, 0);
      r.reject = 1'b1;
    end
    step(1'b1, r);
  endtask

  // Cycle inside DISPENSE or CHANGE with random ignored inputs and maybe a coin
  task automatic noise_step(input bit in_disp, input logic [1:0] p);
    rec_t r = rec(in_disp, p, !in_disp);
    bus.cancel         = 1'($urandom_range(0, 1));
    bus.select_valid   = 1'($urandom_range(0, 1));
    bus.select_product = 2'($urandom_range(0, 3));
    if (in_disp) bus.change_ack = 1'($urandom_range(0, 1));
    else         bus.dispense_ack = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 2) == 0) begin
      bus.coin_valid = 1'b1;
      bus.coin_value = 5'(pick_coin());
      r.reject = 1'b1;
      step(1'b1, r);
    end else begin
      step(1'b0, r);
    end
  endtask

  task automatic refund();
    rec_t r;
    while (m_credit > 0) begin
      for (int i = 0; i < $urandom_range(0, 2); i++) noise_step(1'b0, 2'b00);
      bus.change_ack = 1'b1;
      m_credit -= 5;
      r = rec(0, 2'b00, m_credit > 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.coin_valid = 1'b1;
        bus.coin_value = 5'(pick_coin());
        r.reject = 1'b1;
      end
      step(1'b1, r);
    end
  endtask

  task automatic finish_dispense(input logic [1:0] p);
    rec_t r;
    for (int i = 0; i < $urandom_range(0, 3); i++) noise_step(1'b1, p);
    bus.dispense_ack = 1'b1;
    r = rec(0, 2'b00, m_credit > 0);
    r.sale = 1'b1;
    step(1'b1, r);
    if (m_credit > 0) refund();
  endtask

  task automatic do_select(input logic [1:0] p, input bit with_coin, input int cv, input bit finish);
    rec_t r;
    bus.select_valid   = 1'b1;
    bus.select_product = p;
    if (m_credit == 0 || p == 2'b00) begin
      if (with_coin) put_coin(cv);
      else step(1'b0, '0);
    end else begin
      if (with_coin) begin
        bus.coin_valid = 1'b1;
        bus.coin_value = 5'(cv);
      end
      if (m_credit >= price_of(p)) begin
        m_credit -= price_of(p);
        r = rec(1, p, 0);
        r.reject = with_coin;
        step(1'b1, r);
        if (finish) finish_dispense(p);
      end else begin
        r = rec(0, 2'b00, 0);
        r.insuff = 1'b1;
        r.reject = with_coin;
        step(1'b1, r);
      end
    end
  endtask

  task automatic do_cancel(input bit with_coin, input int cv, input bit finish);
    rec_t r;
    bus.cancel = 1'b1;
    if (m_credit == 0) begin
      if (with_coin) put_coin(cv);
      else step(1'b0, '0);
    end else begin
      r = rec(0, 2'b00, 1);
      if (with_coin) begin
        bus.coin_valid = 1'b1;
        bus.coin_value = 5'(cv);
        r.reject = 1'b1;
      end
      step(1'b1, r);
      if (finish) refund();
    end
  endtask

  task automatic reset_mid(input string name);
    check_drained({name, "_pending"});
    reset = 1'b0;
    #1;
    check_zero(name);
    m_credit = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Scoreboard: any pulse or level change on the outputs is an event to match
  initial begin : monitor
    rec_t prev;
    rec_t cur;
    rec_t e;
    prev = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev = '0;
      end else begin
        cur.reject = bus.coin_reject;
        cur.insuff = bus.insufficient;
        cur.sale   = bus.sale_done;
        cur.dreq   = bus.dispense_req;
        cur.prod   = bus.product;
        cur.creq   = bus.change_req;
        cur.credit = bus.credit;
        cur.busy   = bus.busy;
        if (cur.reject || cur.insuff || cur.sale || (cur.dreq != prev.dreq) ||
            (cur.creq != prev.creq) || (cur.credit != prev.credit) || (cur.busy != prev.busy)) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event at %0t: got %s, want no event", $time, fmt(cur));
          end else begin
            e = exp_q.pop_front();
            if (!e.dreq) cur.prod = e.prod;
            if (cur != e) begin
              miscompares++;
              $display("FAIL event at %0t: got %s, want %s", $time, fmt(cur), fmt(e));
            end
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stimulus
    rec_t r;
    bus.coin_valid     = 1'b0;
    bus.coin_value     = '0;
    bus.select_valid   = 1'b0;
    bus.select_product = 2'b00;
    bus.cancel         = 1'b0;
    bus.dispense_ack   = 1'b0;
    bus.change_ack     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset_state");
    reset = 1'b1;

    // Exact sale, no change
    put_coin(5);
    put_coin(10);
    do_select(2'b11, 1'b0, 0, 1'b1);
    // Sale with two coins of change
    put_coin(20);
    do_select(2'b10, 1'b0, 0, 1'b1);
    // Insufficient credit, then cancel
    put_coin(5);
    do_select(2'b11, 1'b0, 0, 1'b1);
    do_cancel(1'b0, 0, 1'b1);
    // Over-limit and illegal coins
    put_coin(20);
    put_coin(10);
    put_coin(10);
    put_coin(7);
    do_cancel(1'b0, 0, 1'b1);
    // Exactly MAX_CREDIT is accepted, one more coin is not
    put_coin(20);
    put_coin(10);
    put_coin(5);
    put_coin(5);
    do_cancel(1'b0, 0, 1'b1);
    // Inactivity timeout: TIMEOUT quiet cycles, refund on the next edge
    put_coin(10);
    repeat (TIMEOUT) step(1'b0, '0);
    r = rec(0, 2'b00, 1);
    step(1'b1, r);
    refund();
    // Cancel and coin in the same cycle
    put_coin(5);
    do_cancel(1'b1, 10, 1'b1);
    // Reset during DISPENSE, then during CHANGE
    put_coin(10);
    do_select(2'b01, 1'b0, 0, 1'b0);
    repeat (2) step(1'b0, '0);
    reset_mid("reset_in_dispense");
    put_coin(20);
    do_cancel(1'b0, 0, 1'b0);
    repeat (2) step(1'b0, '0);
    reset_mid("reset_in_change");
    put_coin(5);
    do_cancel(1'b0, 0, 1'b1);

    // Random transactions; a periodic cancel keeps quiet spells short of the timeout
    for (int i = 0; i < 200; i++) begin
      if (i % 10 == 9) begin
        do_cancel(1'b0, 0, 1'b1);
      end else begin
        case ($urandom_range(0, 4))
          0, 1: put_coin(pick_coin());
          2:    do_select(2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, pick_coin(), 1'b1);
          3:    do_cancel($urandom_range(0, 3) == 0, pick_coin(), 1'b1);
          default: begin
            for (int k = 0; k < $urandom_range(1, 4); k++) begin
              bus.change_ack   = 1'($urandom_range(0, 1));
              bus.dispense_ack = 1'($urandom_range(0, 1));
              step(1'b0, '0);
            end
          end
        endcase
      end
    end

    repeat (4) step(1'b0, '0);
    check_drained("drain");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
